// File: rtl/rr_mux_arbiter.sv
// ============================================================================
// Module      : rr_mux_arbiter
// Description : 4-way round-robin arbiter feeding one registered output beat
//               with valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_mux_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [3:0]       REQ,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    output logic [3:0]       GNT,
    output logic [WIDTH-1:0] Y,
    output logic [1:0]       S,
    output logic             Y_VALID,
    input  logic             Y_READY
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [1:0]       s_q, s_d;
    logic [1:0]       last_grant_q, last_grant_d;

    logic             capture_slot;
    logic             do_capture;
    logic             found;
    logic [1:0]       idx;
    logic [1:0]       win_idx;
    logic [WIDTH-1:0] win_data;

    // Search starts just past the last winner and wraps, first set bit wins.
    always_comb begin
        found   = 1'b0;
        idx     = 2'd0;
        win_idx = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            idx = 2'(last_grant_q + 2'(i));
            if (!found && REQ[idx]) begin
                found   = 1'b1;
                win_idx = idx;
            end
        end
    end

    always_comb begin
        case (win_idx)
            2'd0:    win_data = A;
            2'd1:    win_data = B;
            2'd2:    win_data = C;
            default: win_data = D;
        endcase
    end

    always_comb begin
        capture_slot = (state_q == IDLE) || Y_READY;
        do_capture   = capture_slot && (REQ != 4'd0);

        state_d      = state_q;
        y_d          = y_q;
        s_d          = s_q;
        last_grant_d = last_grant_q;

        if (do_capture) begin
            state_d      = BUSY;
            y_d          = win_data;
            s_d          = win_idx;
            last_grant_d = win_idx;
        end else if ((state_q == BUSY) && Y_READY) begin
            state_d = IDLE;
        end
    end

    // Gated by reset so no grant escapes while the block is held in reset.
    assign GNT     = (do_capture && RST_N) ? (4'b0001 << win_idx) : 4'b0000;
    assign Y       = y_q;
    assign S       = s_q;
    assign Y_VALID = (state_q == BUSY);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            y_q          <= '0;
            s_q          <= 2'd0;
            last_grant_q <= 2'd3;
        end else begin
            state_q      <= state_d;
            y_q          <= y_d;
            s_q          <= s_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rr_mux_arbiter.sv
// ============================================================================
// Module      : tb_rr_mux_arbiter
// Description : Directed, table-driven self-checking bench for rr_mux_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_mux_arbiter;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic [3:0]       req;
    logic [WIDTH-1:0] a, b, c, d;
    logic [3:0]       gnt;
    logic [WIDTH-1:0] y;
    logic [1:0]       s;
    logic             y_valid;
    logic             y_ready;

    int n_cmp = 0;
    int n_bad = 0;

    rr_mux_arbiter #(.WIDTH(WIDTH)) dut (
        .CLK     (clk),
        .RST_N   (rst_n),
        .REQ     (req),
        .A       (a),
        .B       (b),
        .C       (c),
        .D       (d),
        .GNT     (gnt),
        .Y       (y),
        .S       (s),
        .Y_VALID (y_valid),
        .Y_READY (y_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]       req;
        logic [WIDTH-1:0] a, b, c, d;
        logic             rdy;
        logic [3:0]       exp_gnt;
        logic [WIDTH-1:0] exp_y;
        logic [1:0]       exp_s;
        logic             exp_v;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    initial begin
        // Contention from reset: A first, full rotation, back to A
        vecs[0]  = '{4'b1111, 8'h03, 8'h02, 8'h01, 8'h00, 1'b1, 4'b0001, 8'h03, 2'd0, 1'b1};
        vecs[1]  = '{4'b1111, 8'h03, 8'h02, 8'h01, 8'h00, 1'b1, 4'b0010, 8'h02, 2'd1, 1'b1};
        vecs[2]  = '{4'b1111, 8'h03, 8'h02, 8'h01, 8'h00, 1'b1, 4'b0100, 8'h01, 2'd2, 1'b1};
        vecs[3]  = '{4'b1111, 8'h03, 8'h02, 8'h01, 8'h00, 1'b1, 4'b1000, 8'h00, 2'd3, 1'b1};
        vecs[4]  = '{4'b1111, 8'h03, 8'h02, 8'h01, 8'h00, 1'b1, 4'b0001, 8'h03, 2'd0, 1'b1};
        // Backpressure: five stalled cycles, then B wins
        vecs[5]  = '{4'b1111, 8'h03, 8'h02, 8'h01, 8'h00, 1'b0, 4'b0000, 8'h03, 2'd0, 1'b1};
        vecs[6]  = '{4'b1111, 8'h03, 8'h02, 8'h01, 8'h00, 1'b0, 4'b0000, 8'h03, 2'd0, 1'b1};
        vecs[7]  = '{4'b1111, 8'h03, 8'h02, 8'h01, 8'h00, 1'b0, 4'b0000, 8'h03, 2'd0, 1'b1};
        vecs[8]  = '{4'b1111, 8'h03, 8'h02, 8'h01, 8'h00, 1'b0, 4'b0000, 8'h03, 2'd0, 1'b1};
        vecs[9]  = '{4'b1111, 8'h03, 8'h02, 8'h01, 8'h00, 1'b0, 4'b0000, 8'h03, 2'd0, 1'b1};
        vecs[10] = '{4'b1111, 8'h03, 8'h02, 8'h01, 8'h00, 1'b1, 4'b0010, 8'h02, 2'd1, 1'b1};
        // Drain, then ready ignored in IDLE
        vecs[11] = '{4'b0000, 8'h03, 8'h02, 8'h01, 8'h00, 1'b1, 4'b0000, 8'h02, 2'd1, 1'b0};
        vecs[12] = '{4'b0000, 8'h03, 8'h02, 8'h01, 8'h00, 1'b1, 4'b0000, 8'h02, 2'd1, 1'b0};
        // Single requester from IDLE (ready low still captures)
        vecs[13] = '{4'b0010, 8'h03, 8'h22, 8'h01, 8'h00, 1'b0, 4'b0010, 8'h22, 2'd1, 1'b1};
        vecs[14] = '{4'b1000, 8'h03, 8'h22, 8'h01, 8'h44, 1'b1, 4'b1000, 8'h44, 2'd3, 1'b1};
        // Wrap-around: last grant D, REQ=1001 -> A then D
        vecs[15] = '{4'b1001, 8'h11, 8'h22, 8'h01, 8'h44, 1'b1, 4'b0001, 8'h11, 2'd0, 1'b1};
        vecs[16] = '{4'b1001, 8'h11, 8'h22, 8'h01, 8'h44, 1'b1, 4'b1000, 8'h44, 2'd3, 1'b1};
        vecs[17] = '{4'b0000, 8'h11, 8'h22, 8'h01, 8'h44, 1'b1, 4'b0000, 8'h44, 2'd3, 1'b0};
        vecs[18] = '{4'b0100, 8'h11, 8'h22, 8'h5A, 8'h44, 1'b0, 4'b0100, 8'h5A, 2'd2, 1'b1};

        rst_n   = 1'b0;
        req     = 4'd0;
        a = '0; b = '0; c = '0; d = '0;
        y_ready = 1'b0;

        #1;
        chk("reset_valid", -1, 32'(y_valid), 32'd0);
        chk("reset_y",     -1, 32'(y),       32'd0);
        chk("reset_gnt",   -1, 32'(gnt),     32'd0);

        // Build a held beat Y=55, then assert reset mid-cycle
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b0001;
        a     = 8'h55;
        #1;
        chk("pre_gnt", -2, 32'(gnt), 32'b0001);
        @(posedge clk);
        #1;
        chk("pre_valid", -2, 32'(y_valid), 32'd1);
        chk("pre_y",     -2, 32'(y),       32'h55);
        y_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", -3, 32'(y_valid), 32'd0);
        chk("async_y",     -3, 32'(y),       32'd0);
        chk("async_s",     -3, 32'(s),       32'd0);
        chk("async_gnt",   -3, 32'(gnt),     32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 19; i++) begin
            req     = vecs[i].req;
            a       = vecs[i].a;
            b       = vecs[i].b;
            c       = vecs[i].c;
            d       = vecs[i].d;
            y_ready = vecs[i].rdy;
            #1;
            chk("gnt", i, 32'(gnt), 32'(vecs[i].exp_gnt));
            @(posedge clk);
            #1;
            chk("y",       i, 32'(y),       32'(vecs[i].exp_y));
            chk("s",       i, 32'(s),       32'(vecs[i].exp_s));
            chk("y_valid", i, 32'(y_valid), 32'(vecs[i].exp_v));
            @(negedge clk);
        end

        // C dropped without a grant: only removes it from arbitration
        req     = 4'b0110;
        y_ready = 1'b0;
        #1;
        chk("stall_gnt", 19, 32'(gnt), 32'd0);
        req = 4'b0010;
        @(negedge clk);
        y_ready = 1'b1;
        #1;
        chk("drop_gnt", 20, 32'(gnt), 32'b0010);
        @(posedge clk);
        #1;
        chk("drop_y", 20, 32'(y), 32'h22);
        chk("drop_s", 20, 32'(s), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001: Parameter WIDTH, default 8, data width of each requester and of Y.
REQ-002: CLK  input  1  rising-edge clock, sole clock of the block.
REQ-003: RST_N  input  1  reset, asynchronous, active-low.
REQ-004: REQ  input  4  request lines; bit 0..3 = requester A..D.
REQ-005: A, B, C, D  input  WIDTH  requester data, each held stable while its REQ bit is high.
REQ-006: GNT  output  4  one-hot grant, high in the cycle the granted requester's data is captured.
REQ-007: Y  output  WIDTH  registered output data.
REQ-008: S  output  2  registered select of the beat currently in Y (0=A … 3=D).
REQ-009: Y_VALID  output  1  Y holds a beat not yet accepted downstream.
REQ-010: Y_READY  input  1  downstream accepts Y when Y_VALID and Y_READY are both high at a rising edge.

Function
REQ-011: The block SHALL implement a two-state FSM with states IDLE (Y_VALID=0) and BUSY (Y_VALID=1).
REQ-012: The block SHALL define a capture slot as (IDLE) or (BUSY and Y_READY=1).
REQ-013: In a capture slot with REQ≠0, the block SHALL drive GNT combinationally, one-hot, to the round-robin winner.
REQ-014: On that same edge, the block SHALL load Y with the winner's data and S with the winner's index, and SHALL enter or stay in BUSY.
REQ-015: GNT SHALL be 0 outside capture slots, when REQ=0, and while RST_N=0.
REQ-016: Round-robin SHALL search from index (last_grant+1) mod 4 upward, wrapping 3→0; the first set REQ bit wins.
REQ-017: last_grant SHALL update only on a capture; it SHALL reset to 3, so A has top priority first.
REQ-018: In a capture slot with REQ=0, the block SHALL go from BUSY to IDLE on a Y_READY acceptance, and SHALL stay in IDLE otherwise.
REQ-019: In BUSY with Y_READY=0, Y, S, last_grant and state SHALL hold, and GNT SHALL be 0 regardless of REQ.
REQ-020: Back-to-back operation SHALL be supported: acceptance and a new capture on the same edge give one beat per cycle, with no bubble.
REQ-021: Latency SHALL be one cycle: data captured at edge N is on Y with Y_VALID=1 after edge N.
REQ-022: Y and S SHALL change only on a capture edge; they SHALL hold their last value in IDLE.
REQ-023: A REQ bit dropping without a grant SHALL simply remove that requester from arbitration, with no other effect.
REQ-024: Y_READY while in IDLE SHALL be ignored.

Reset
REQ-025: RST_N=0 SHALL immediately, without a clock, force Y=0, S=0, Y_VALID=0, GNT=0, state=IDLE and last_grant=3.
REQ-026: A reset asserted during BUSY SHALL discard the held beat; a beat in Y is never presented after reset.
REQ-027: After RST_N rises, the first capture SHALL occur at the first rising edge with REQ≠0.

Verification
REQ-028: Reset check: RST_N=0 mid-cycle with Y_VALID=1, Y=8'h55 -> Y_VALID=0, Y=0, S=0, GNT=0 before the next CLK edge.
REQ-029: Single requester: REQ=4'b0010, B=8'h22, Y_READY=1 from IDLE -> GNT=4'b0010 for one cycle; next cycle Y=8'h22, S=2'b01, Y_VALID=1.
REQ-030: Full contention: REQ=4'b1111, A/B/C/D=8'h03/02/01/00, Y_READY=1 -> GNT=0001,0010,0100,1000,0001 on consecutive cycles; Y sequence 03,02,01,00,03 with no gap.
REQ-031: Backpressure: Y_VALID=1, Y=8'h03, Y_READY=0 for 5 cycles with REQ=4'b1111 -> Y, S stable, GNT=0 throughout; first grant after Y_READY=1 goes to B.
REQ-032: Wrap-around: last grant to D, then REQ=4'b1001 -> GNT=4'b0001 (A) first, then 4'b1000.
REQ-033: Drain: single beat accepted with REQ=0 -> Y_VALID falls after the acceptance edge, Y holds its value, state=IDLE.
